// File: rtl/execute_muldiv_unit.sv
// execute_muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage.
// One radix-2 step per cycle; start/busy/done handshake towards the hazard unit.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish divide-by-zero and
// signed-overflow divides in IDLE (DoneE in cycle 1, BusyE never rises).
module execute_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StartE,
    input  logic                  FlushE,
    input  logic [2:0]            MulDivCtrlE,
    input  logic [DATA_WIDTH-1:0] SrcAE,
    input  logic [DATA_WIDTH-1:0] SrcBE,
    output logic [DATA_WIDTH-1:0] ResultE,
    output logic                  BusyE,
    output logic                  DoneE
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ONES     = {W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [W-1:0]     result_q, result_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             sign_a_q, sign_a_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic             in_is_div;
    logic             in_a_signed;
    logic             in_b_signed;
    logic             in_sign_a;
    logic             in_sign_b;
    logic             in_zero;
    logic             in_ovf;
    logic [W-1:0]     in_abs_a;
    logic [W-1:0]     in_abs_b;

    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic [2*W-1:0]   mul_step;
    logic [2*W-1:0]   div_step;
    logic [2*W-1:0]   mul_fix;
    logic [W-1:0]     mul_res;
    logic [W-1:0]     quo_fix;
    logic [W-1:0]     rem_fix;
    logic [W-1:0]     div_res;

    // Decode the incoming op: signedness, operand magnitudes and divide corner cases.
    always_comb begin
        in_is_div   = MulDivCtrlE[2];
        in_a_signed = (MulDivCtrlE == 3'd1) || (MulDivCtrlE == 3'd2) ||
                      (MulDivCtrlE == 3'd4) || (MulDivCtrlE == 3'd6);
        in_b_signed = (MulDivCtrlE == 3'd1) || (MulDivCtrlE == 3'd4) ||
                      (MulDivCtrlE == 3'd6);
        in_sign_a   = in_a_signed && SrcAE[W-1];
        in_sign_b   = in_b_signed && SrcBE[W-1];
        in_abs_a    = in_sign_a ? -SrcAE : SrcAE;
        in_abs_b    = in_sign_b ? -SrcBE : SrcBE;
        in_zero     = in_is_div && (SrcBE == '0);
        in_ovf      = in_is_div && !MulDivCtrlE[0] && (SrcAE == MIN_VAL) && (SrcBE == ONES);
    end

    // One iteration step of each datapath, plus the sign fix-up and corner selection used in FIX.
    always_comb begin
        mul_sum   = acc_q[0] ? ({1'b0, acc_q[2*W-1:W]} + {1'b0, op_a_q})
                             : {1'b0, acc_q[2*W-1:W]};
        mul_step  = {mul_sum, acc_q[W-1:1]};
        div_shift = acc_q[2*W-1:W-1];
        div_diff  = div_shift - {1'b0, op_b_q};
        div_step  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
        mul_fix   = neg_q ? -acc_q : acc_q;
        mul_res   = (ctrl_q[1:0] == 2'd0) ? mul_fix[W-1:0] : mul_fix[2*W-1:W];
        quo_fix   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix   = sign_a_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (div_zero_q) begin
            div_res = ctrl_q[1] ? (sign_a_q ? -op_a_q : op_a_q) : ONES;
        end else if (ovf_q) begin
            div_res = ctrl_q[1] ? '0 : MIN_VAL;
        end else begin
            div_res = ctrl_q[1] ? rem_fix : quo_fix;
        end
    end

    // Next-state logic of the IDLE -> CALC -> FIX -> DONE sequencer; a flush overrides everything.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        result_d   = result_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (StartE) begin
                    ctrl_d     = MulDivCtrlE;
                    op_a_d     = in_abs_a;
                    op_b_d     = in_abs_b;
                    acc_d      = in_is_div ? {{W{1'b0}}, in_abs_a} : {{W{1'b0}}, in_abs_b};
                    neg_d      = in_sign_a ^ in_sign_b;
                    sign_a_d   = in_sign_a;
                    div_zero_d = in_zero;
                    ovf_d      = in_ovf;
                    cnt_d      = '0;
                    state_d    = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (in_zero || in_ovf) begin
                        state_d  = S_DONE;
                        result_d = in_zero ? (MulDivCtrlE[1] ? SrcAE : ONES)
                                           : (MulDivCtrlE[1] ? '0 : MIN_VAL);
                    end
`endif
                end
            end
            S_CALC: begin
                acc_d = ctrl_q[2] ? div_step : mul_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = ctrl_q[2] ? div_res : mul_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (FlushE) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            result_q   <= result_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            sign_a_q   <= sign_a_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ResultE = result_q;
    assign BusyE   = (state_q == S_CALC) || (state_q == S_FIX);
    assign DoneE   = (state_q == S_DONE);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// tb_execute_muldiv_unit: scoreboard-based bench for execute_muldiv_unit (DATA_WIDTH=32).
// Honours MULDIV_EARLY_OUT_EN for the expected latency of divide corner cases.
`timescale 1ns/1ps
module tb_execute_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int CORNER_LAT  = 1;
    localparam int CORNER_BUSY = 0;
`else
    localparam int CORNER_LAT  = 34;
    localparam int CORNER_BUSY = 33;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
        int          busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  MulDivCtrlE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [31:0] ResultE;
    logic        BusyE;
    logic        DoneE;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_result  = 32'h0;

    execute_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .StartE      (StartE),
        .FlushE      (FlushE),
        .MulDivCtrlE (MulDivCtrlE),
        .SrcAE       (SrcAE),
        .SrcBE       (SrcBE),
        .ResultE     (ResultE),
        .BusyE       (BusyE),
        .DoneE       (DoneE)
    );

    always #5 clk = ~clk;

    // Reference RV32M semantics using native wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        logic [31:0] r;
        ea = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 3'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        if (op == 3'd0) begin
            r = p[31:0];
        end else if (!op[2]) begin
            r = p[63:32];
        end else if (b == 32'h0) begin
            r = op[1] ? a : 32'hFFFFFFFF;
        end else if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = op[1] ? 32'h0 : 32'h80000000;
        end else begin
            case (op)
                3'd4:    r = $signed(a) / $signed(b);
                3'd5:    r = a / b;
                3'd6:    r = $signed(a) % $signed(b);
                default: r = a % b;
            endcase
        end
        return r;
    endfunction

    // Drive one start pulse so that it is sampled at the next rising edge (edge 0).
    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected);
        @(negedge clk);
        StartE      = 1'b1;
        MulDivCtrlE = op;
        SrcAE       = a;
        SrcBE       = b;
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
        StartE = 1'b0;
    endtask

    // Count cycles after the accepting edge until DoneE; optionally re-pulse StartE or FlushE.
    task automatic wait_done(input int max_cyc, input int pulse_at, input int flush_at,
                             output int done_cyc, output int busy_cnt, output int busy_last,
                             output logic [31:0] res);
        done_cyc  = 0;
        busy_cnt  = 0;
        busy_last = 0;
        res       = 32'hx;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (BusyE === 1'b1) begin
                busy_cnt++;
                busy_last = k;
            end
            if (DoneE === 1'b1) begin
                done_cyc = k;
                res      = ResultE;
                break;
            end
            StartE = (k == pulse_at);
            FlushE = (k == flush_at);
            if (k == pulse_at) begin
                MulDivCtrlE = 3'd5;
                SrcAE       = 32'd100;
                SrcBE       = 32'd7;
            end
        end
        StartE = 1'b0;
        FlushE = 1'b0;
    endtask

    function automatic logic [31:0] pop_exp();
        logic [31:0] e;
        e = 32'hx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ResultE !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_result: got %h, expected %h", ResultE, 32'h0); end
        tests_run++;
        if (BusyE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", BusyE); end
        tests_run++;
        if (DoneE !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b, expected 0", DoneE); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (BusyE !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_busy: got %b, expected 0", BusyE); end
    endtask

    task automatic test_muldiv;
        vec_t        vecs[12];
        int          cyc, bcnt, blast;
        logic [31:0] res, e;
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 33};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34, 33};
        vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 33};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, 33};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 33};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 33};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       34, 33};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34, 33};
        vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, CORNER_LAT, CORNER_BUSY};
        vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        CORNER_LAT, CORNER_BUSY};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, CORNER_LAT, CORNER_BUSY};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        CORNER_LAT, CORNER_BUSY};
        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
            wait_done(40, 0, 0, cyc, bcnt, blast, res);
            e = pop_exp();
            last_result = e;
            tests_run++;
            if (res !== e) begin tests_failed++; $display("[TB] FAIL result[%0d] op%0d: got %h, expected %h", i, vecs[i].op, res, e); end
            tests_run++;
            if (cyc != vecs[i].lat) begin tests_failed++; $display("[TB] FAIL latency[%0d]: got %0d, expected %0d", i, cyc, vecs[i].lat); end
            tests_run++;
            if (bcnt != vecs[i].busy || (bcnt > 0 && blast != vecs[i].busy)) begin
                tests_failed++;
                $display("[TB] FAIL busy[%0d]: got %0d cycles (last %0d), expected %0d", i, bcnt, blast, vecs[i].busy);
            end
            @(negedge clk);
            tests_run++;
            if (DoneE !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_pulse[%0d]: got %b, expected 0", i, DoneE); end
        end
    endtask

    task automatic test_random;
        int          cyc, bcnt, blast, lat;
        logic [2:0]  op;
        logic [31:0] a, b, res, e;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            lat = (op[2] && (b == 32'h0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? CORNER_LAT : 34;
            launch(op, a, b, model(op, a, b));
            wait_done(40, 0, 0, cyc, bcnt, blast, res);
            e = pop_exp();
            last_result = e;
            tests_run++;
            if (res !== e || cyc != lat) begin
                tests_failed++;
                $display("[TB] FAIL random[%0d] op%0d a=%h b=%h: got %h at %0d, expected %h at %0d", i, op, a, b, res, cyc, e, lat);
            end
        end
    endtask

    task automatic test_restart_ignored;
        int          cyc, bcnt, blast;
        logic [31:0] res, e;
        launch(3'd0, 32'd3, 32'd5, 32'd15);
        wait_done(40, 5, 0, cyc, bcnt, blast, res);
        e = pop_exp();
        last_result = e;
        tests_run++;
        if (res !== e) begin tests_failed++; $display("[TB] FAIL restart_result: got %h, expected %h", res, e); end
        tests_run++;
        if (cyc != 34) begin tests_failed++; $display("[TB] FAIL restart_latency: got %0d, expected 34", cyc); end
    endtask

    task automatic test_flush;
        int          cyc, bcnt, blast;
        logic [31:0] res;
        launch(3'd0, 32'd6, 32'd7, 32'd42);
        wait_done(40, 0, 10, cyc, bcnt, blast, res);
        exp_q.delete();
        tests_run++;
        if (cyc != 0) begin tests_failed++; $display("[TB] FAIL flush_no_done: got DoneE at %0d, expected none", cyc); end
        tests_run++;
        if (bcnt != 10 || blast != 10) begin tests_failed++; $display("[TB] FAIL flush_busy: got %0d cycles (last %0d), expected 10", bcnt, blast); end
        tests_run++;
        if (ResultE !== last_result) begin tests_failed++; $display("[TB] FAIL flush_hold: got %h, expected %h", ResultE, last_result); end
    endtask

    task automatic test_reset_mid_op;
        int          cyc, bcnt, blast;
        logic [31:0] res, e;
        launch(3'd0, 32'd9, 32'd9, 32'd81);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (BusyE !== 1'b0 || DoneE !== 1'b0 || ResultE !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_op: got busy=%b done=%b result=%h, expected 0/0/0", BusyE, DoneE, ResultE);
        end
        #2;
        rst = 1'b0;
        exp_q.delete();
        last_result = 32'h0;
        wait_done(40, 0, 0, cyc, bcnt, blast, res);
        tests_run++;
        if (cyc != 0) begin tests_failed++; $display("[TB] FAIL reset_no_done: got DoneE at %0d, expected none", cyc); end
        launch(3'd0, 32'd3, 32'd4, 32'd12);
        wait_done(40, 0, 0, cyc, bcnt, blast, res);
        e = pop_exp();
        last_result = e;
        tests_run++;
        if (res !== e || cyc != 34) begin tests_failed++; $display("[TB] FAIL after_reset_mul: got %h at %0d, expected %h at 34", res, cyc, e); end
    endtask

    task automatic test_back_to_back;
        int          cyc, bcnt, blast;
        logic [31:0] res, e;
        launch(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        wait_done(40, 0, 0, cyc, bcnt, blast, res);
        e = pop_exp();
        last_result = e;
        tests_run++;
        if (res !== e || cyc != 34) begin tests_failed++; $display("[TB] FAIL b2b_first: got %h at %0d, expected %h at 34", res, cyc, e); end
        StartE      = 1'b1;
        MulDivCtrlE = 3'd5;
        SrcAE       = 32'd1000;
        SrcBE       = 32'd9;
        exp_q.push_back(model(3'd5, 32'd1000, 32'd9));
        @(posedge clk);
        @(posedge clk);
        #1;
        StartE = 1'b0;
        wait_done(40, 0, 0, cyc, bcnt, blast, res);
        e = pop_exp();
        last_result = e;
        tests_run++;
        if (res !== e) begin tests_failed++; $display("[TB] FAIL b2b_second_result: got %h, expected %h", res, e); end
        tests_run++;
        if (cyc != 34) begin tests_failed++; $display("[TB] FAIL b2b_second_latency: got %0d, expected 34", cyc); end
    endtask

    initial begin
        rst         = 1'b1;
        StartE      = 1'b0;
        FlushE      = 1'b0;
        MulDivCtrlE = 3'd0;
        SrcAE       = 32'h0;
        SrcBE       = 32'h0;
        test_reset();
        test_muldiv();
        test_random();
        test_restart_ignored();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
